half_adder_sync: RTL and testbench

- Bitwise half adder with combinational outputs plus a one-cycle registered copy of the result and a valid flag.
- Leaf arithmetic primitive. Full adders, incrementers and lab-level datapaths build on it.
- The combinational path gives zero-latency sum/carry for unclocked use. The registered path gives a pipelined, reset-clean result for clocked datapaths.

---
 rtl/half_adder_sync_pkg.sv | 10 +
 rtl/half_adder_bit.sv | 19 +
 rtl/half_adder_sync_chk.sv | 17 +
 rtl/half_adder_sync.sv | 89 ++++++++
 tb/tb_half_adder_sync.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/half_adder_sync_pkg.sv
// -----------------------------------------------------------------------------
// half_adder_sync_pkg
// Shared constants for the half_adder_sync block.
//   HA_MAX_WIDTH : largest legal number of half-adder lanes.
// -----------------------------------------------------------------------------
package half_adder_sync_pkg;

   localparam int HA_MAX_WIDTH = 64;

endpackage : half_adder_sync_pkg

// File: rtl/half_adder_bit.sv
// -----------------------------------------------------------------------------
// half_adder_bit
// Single-lane combinational half adder.
// Ports:
//   a, b   : input  1-bit addends
//   sum    : output a XOR b
//   carry  : output a AND b
// -----------------------------------------------------------------------------
module half_adder_bit (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule : half_adder_bit

// File: rtl/half_adder_sync_chk.sv
// -----------------------------------------------------------------------------
// half_adder_sync_chk
// Elaboration-time parameter checker for half_adder_sync.
// Ports: none; WIDTH is the lane count of the enclosing instance.
// -----------------------------------------------------------------------------
module half_adder_sync_chk
   import half_adder_sync_pkg::*;
#(
   parameter int WIDTH = 1
) ();

   // Reject lane counts outside 1..HA_MAX_WIDTH when the design is elaborated.
   if ((WIDTH < 1) || (WIDTH > HA_MAX_WIDTH)) begin : g_bad_width
      $error("half_adder_sync: WIDTH=%0d outside 1..%0d", WIDTH, HA_MAX_WIDTH);
   end

endmodule : half_adder_sync_chk

// File: rtl/half_adder_sync.sv
// -----------------------------------------------------------------------------
// half_adder_sync
// WIDTH independent half-adder lanes with a zero-latency combinational result
// and an optional one-cycle registered copy qualified by a valid flag.
// Ports:
//   clk       : input  system clock, rising edge
//   rst       : input  synchronous active-high reset
//   in_valid  : input  qualifies a/b for the registered path
//   a, b      : input  [WIDTH] addends
//   sum       : output [WIDTH] a ^ b (combinational)
//   carry     : output [WIDTH] a & b (combinational)
//   sum_q     : output [WIDTH] registered sum
//   carry_q   : output [WIDTH] registered carry
//   out_valid : output registered in_valid
// REG_OUT=0 ties sum_q/carry_q/out_valid to zero and builds no flops.
// -----------------------------------------------------------------------------
module half_adder_sync
   import half_adder_sync_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             out_valid
);

   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] carry_s;

   half_adder_sync_chk #(.WIDTH(WIDTH)) u_chk ();

   // One cell per lane keeps lanes fully independent, so X stays in its lane.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_bit u_bit (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (sum_s[i]),
         .carry (carry_s[i])
      );
   end

   assign sum   = sum_s;
   assign carry = carry_s;

   if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] sum_r;
      logic [WIDTH-1:0] carry_r;
      logic             valid_r;

      // Capture the lane results when qualified; reset wins over in_valid.
      always_ff @(posedge clk) begin
         if (rst) begin
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
         end else begin
            valid_r <= in_valid;
            if (in_valid) begin
               sum_r   <= sum_s;
               carry_r <= carry_s;
            end else begin
               sum_r   <= sum_r;
               carry_r <= carry_r;
            end
         end
      end

      assign sum_q     = sum_r;
      assign carry_q   = carry_r;
      assign out_valid = valid_r;
   end else begin : g_noreg
      // Clock-side inputs are intentionally unused in the flop-free variant.
      logic unused_s;
      assign unused_s  = ^{clk, rst, in_valid};

      assign sum_q     = {WIDTH{1'b0}};
      assign carry_q   = {WIDTH{1'b0}};
      assign out_valid = 1'b0;
   end

endmodule : half_adder_sync

// File: tb/tb_half_adder_sync.sv
// -----------------------------------------------------------------------------
// tb_half_adder_sync
// Self-checking bench for half_adder_sync: a 1-lane registered instance, an
// 8-lane registered instance with a result scoreboard, and an 8-lane
// REG_OUT=0 instance driven with random data.
// -----------------------------------------------------------------------------
module tb_half_adder_sync;

   typedef struct packed {
      logic [7:0] s;
      logic [7:0] c;
   } res_t;

   logic clk = 1'b0;
   logic rst;

   // Clock generator, 10 time-unit period.
   always #5 clk = ~clk;

   // 1-lane registered instance
   logic v1, a1, b1, s1, c1, sq1, cq1, ov1;
   // 8-lane registered instance
   logic       v8, ov8;
   logic [7:0] a8, b8, s8, c8, sq8, cq8;
   // 8-lane instance without output registers
   logic       v0, ov0;
   logic [7:0] a0, b0, s0, c0, sq0, cq0;

   half_adder_sync #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
      .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
   );

   half_adder_sync #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
      .sum(s8), .carry(c8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8)
   );

   half_adder_sync #(.WIDTH(8), .REG_OUT(1'b0)) u_w0 (
      .clk(clk), .rst(rst), .in_valid(v0), .a(a0), .b(b0),
      .sum(s0), .carry(c0), .sum_q(sq0), .carry_q(cq0), .out_valid(ov0)
   );

   int   npass  = 0;
   int   ntotal = 0;
   res_t sb[$];
   res_t hold;
   logic pend_v;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drive the 8-lane instance, check its combinational outputs, queue the result.
   task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b);
      res_t r;
      v8 = v;
      a8 = a;
      b8 = b;
      #1;
      chk("w8_sum", {8'h00, s8}, {8'h00, a ^ b});
      chk("w8_carry", {8'h00, c8}, {8'h00, a & b});
      if (v) begin
         r.s = a ^ b;
         r.c = a & b;
         sb.push_back(r);
      end
      pend_v = v;
   endtask

   // Advance one edge and compare registered outputs with the scoreboard.
   task automatic cycle8();
      @(posedge clk);
      #1;
      chk("w8_out_valid", {15'h0000, ov8}, {15'h0000, pend_v});
      if (pend_v) begin
         chk("w8_sb_depth", 16'(sb.size()), 16'd1);
         if (sb.size() > 0) hold = sb.pop_front();
      end
      chk("w8_sum_q", {8'h00, sq8}, {8'h00, hold.s});
      chk("w8_carry_q", {8'h00, cq8}, {8'h00, hold.c});
   endtask

   initial begin
      logic [1:0] ab;
      logic [7:0] ra, rb;

      rst = 1'b1;
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      v0 = 1'b0; a0 = 8'h00; b0 = 8'h00;
      hold   = '0;
      pend_v = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_w1_q", {13'h0000, ov1, sq1, cq1}, 16'h0000);
      chk("rst_w8_valid", {15'h0000, ov8}, 16'h0000);
      chk("rst_w8_q", {sq8, cq8}, 16'h0000);
      rst = 1'b0;

      // 1-lane truth table, no clock dependence
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         a1 = ab[1];
         b1 = ab[0];
         #10;
         chk("w1_sum", {15'h0000, s1}, {15'h0000, ab[1] ^ ab[0]});
         chk("w1_carry", {15'h0000, c1}, {15'h0000, ab[1] & ab[0]});
      end

      // 1-lane registered capture then hold
      @(posedge clk);
      #1;
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
      @(posedge clk);
      #1;
      chk("w1_load", {13'h0000, ov1, sq1, cq1}, 16'h0005);
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      @(posedge clk);
      #1;
      chk("w1_hold", {13'h0000, ov1, sq1, cq1}, 16'h0001);

      // 8-lane directed values
      drive8(1'b1, 8'hF0, 8'hCC);
      cycle8();
      drive8(1'b0, 8'h12, 8'h34);
      cycle8();

      // Reset mid-stream with in_valid high discards the in-flight result
      drive8(1'b1, 8'hFF, 8'hFF);
      cycle8();
      rst = 1'b1;
      v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk);
      #1;
      chk("rst_mid_valid", {15'h0000, ov8}, 16'h0000);
      chk("rst_mid_q", {sq8, cq8}, 16'h0000);
      chk("rst_mid_carry", {8'h00, c8}, 16'h00FF);
      rst = 1'b0;
      hold = '0;
      pend_v = 1'b0;
      drive8(1'b0, 8'hFF, 8'hFF);
      cycle8();

      // Streaming: one result every cycle, no gaps or duplicates
      for (int i = 0; i < 256; i++) begin
         drive8(1'b1, 8'(i), 8'h55);
         cycle8();
      end
      drive8(1'b0, 8'h00, 8'h00);
      cycle8();
      chk("w8_sb_drained", 16'(sb.size()), 16'd0);

      // REG_OUT=0 with random stimulus
      for (int i = 0; i < 50; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         v0 = 1'($urandom);
         a0 = ra;
         b0 = rb;
         @(posedge clk);
         #1;
         chk("w0_sum", {8'h00, s0}, {8'h00, ra ^ rb});
         chk("w0_carry", {8'h00, c0}, {8'h00, ra & rb});
         chk("w0_q", {7'h00, ov0, sq0 | cq0}, 16'h0000);
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule : tb_half_adder_sync
